// File: rtl/axis_framer_pkg.sv
// Shared types and constants for the AXI-Stream sample framer.
// The AXIS_FRAMER_HEADER_EN build uses the HEADER state and HEADER_MAGIC.
package axis_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  localparam logic [15:0] HEADER_MAGIC = 16'hAD76;
  localparam int          OVF_CNT_W    = 16;

endpackage

// File: rtl/axis_sample_framer_if.sv
// AXI-Stream bundle used on both sides of the framer.
interface axis_sample_framer_if #(
  parameter int DATA_W = 32
) ();
  // A beat transfers on a rising edge where tvalid & tready are both 1. Once
  // tvalid is high, tdata/tlast stay stable until that beat; tready may toggle freely.
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_framer_fifo.sv
// First-word-fall-through sample FIFO; a push while full is taken when a pop
// happens in the same cycle.
module axis_framer_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/axis_sample_framer.sv
// Packs 24-bit ADC samples into fixed-length sign-extended AXIS frames with tlast.
// Define AXIS_FRAMER_HEADER_EN to prefix each frame with {HEADER_MAGIC, seq}.
module axis_sample_framer
  import axis_framer_pkg::*;
#(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_sample_framer_if.slave  s_axis,
  axis_sample_framer_if.master m_axis,
  input  logic                 enable,
  input  logic                 overflow_clr,
  output logic [OVF_CNT_W-1:0] overflow_cnt,
  output logic                 busy,
  output state_t               dbg_state
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_t               state;
  logic [CNT_W-1:0]     in_cnt;
  logic [CNT_W-1:0]     ld_cnt;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [IN_WIDTH-1:0]  fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 out_free;
  logic                 out_hs;
  logic                 pop;
  logic                 attempt;
  logic                 store;
  logic                 drop;
  logic                 start;
  logic [OUT_WIDTH-1:0] sext_word;
  logic                 unused_s_tlast;
`ifdef AXIS_FRAMER_HEADER_EN
  logic [15:0]          seq;
`endif

  assign unused_s_tlast = s_axis.tlast;
  assign s_axis.tready  = s_ready;
  assign m_axis.tdata   = out_data;
  assign m_axis.tvalid  = out_valid;
  assign m_axis.tlast   = out_last;
  assign dbg_state      = state;
  assign busy           = (state != ST_IDLE) || !fifo_empty;

  assign out_free  = !out_valid || m_axis.tready;
  assign out_hs    = out_valid && m_axis.tready;
  assign pop       = (state == ST_DATA) && !fifo_empty && out_free && (ld_cnt != CNT_W'(FRAME_LEN));
  // in_cnt != 0 means the input side is mid-frame, so the rest of the frame is
  // taken even after enable falls; only a fresh frame needs enable.
  assign attempt   = s_ready && s_axis.tvalid && ((in_cnt != '0) || enable);
  assign store     = attempt && (!fifo_full || pop);
  assign drop      = attempt && !store;
  assign start     = (state == ST_IDLE) && (store || !fifo_empty);
  assign sext_word = OUT_WIDTH'($signed(fifo_dout));

  axis_framer_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (store),
    .push_data (s_axis.tdata),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_ready      <= 1'b0;
      in_cnt       <= '0;
      overflow_cnt <= '0;
    end else begin
      s_ready <= 1'b1;
      if (store) in_cnt <= (in_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : in_cnt + 1'b1;
      if (overflow_clr)                  overflow_cnt <= drop ? OVF_CNT_W'(1) : '0;
      else if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      ld_cnt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef AXIS_FRAMER_HEADER_EN
      seq       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef AXIS_FRAMER_HEADER_EN
            state     <= ST_HEADER;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= OUT_WIDTH'({HEADER_MAGIC, seq});
`else
            state     <= ST_DATA;
`endif
          end
        end
        ST_HEADER: begin
          if (out_hs) begin
            state     <= ST_DATA;
            out_valid <= 1'b0;
          end
        end
        ST_DATA: begin
          if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sext_word;
            out_last  <= (ld_cnt == CNT_W'(FRAME_LEN - 1));
            ld_cnt    <= ld_cnt + 1'b1;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          // No pop can coincide with the tlast beat: ld_cnt is already FRAME_LEN.
          if (out_hs && out_last) begin
            state  <= ST_IDLE;
            ld_cnt <= '0;
`ifdef AXIS_FRAMER_HEADER_EN
            seq    <= seq + 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_sample_framer.sv
// Bench for axis_sample_framer with FRAME_LEN=4, FIFO_DEPTH=16; follows AXIS_FRAMER_HEADER_EN.
module tb_axis_sample_framer;
  import axis_framer_pkg::*;

  localparam int IN_W  = 24;
  localparam int OUT_W = 32;
  localparam int FLEN  = 4;
  localparam int DEPTH = 16;
`ifdef AXIS_FRAMER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  // Samples held while the output is stalled: FIFO plus the output register,
  // unless a pending header occupies that register.
  localparam int CAP = HDR ? DEPTH : DEPTH + 1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        overflow_clr = 1'b0;
  logic [15:0] overflow_cnt;
  logic        busy;
  state_t      dbg_state;

  axis_sample_framer_if #(.DATA_W(IN_W))  s_if ();
  axis_sample_framer_if #(.DATA_W(OUT_W)) m_if ();

  axis_sample_framer #(
    .IN_WIDTH   (IN_W),
    .OUT_WIDTH  (OUT_W),
    .FRAME_LEN  (FLEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .enable       (enable),
    .overflow_clr (overflow_clr),
    .overflow_cnt (overflow_cnt),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [OUT_W:0]  exp_q[$];
  logic [OUT_W:0]  obs_q[$];
  int              open_cnt = 0;
  logic [15:0]     seq_m = '0;
  int              exp_ovf = 0;

  // Reference model: frames are runs of FLEN stored samples; a new run needs enable.
  function automatic bit model_accepts();
    return (open_cnt != 0) || (enable == 1'b1);
  endfunction

  function automatic void model_store(logic [IN_W-1:0] d);
    logic signed [IN_W-1:0] sd;
    int                     w;
    if (open_cnt == 0 && HDR) exp_q.push_back({1'b0, 16'hAD76, seq_m});
    sd = d;
    w  = sd;
    open_cnt++;
    exp_q.push_back({(open_cnt == FLEN), w[OUT_W-1:0]});
    if (open_cnt == FLEN) begin
      open_cnt = 0;
      seq_m++;
    end
  endfunction

  // Output monitor: records beats and checks stalled beats stay put.
  logic           stall_prev = 1'b0;
  logic [OUT_W:0] stall_word = '0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || {m_if.tlast, m_if.tdata} !== stall_word) begin
          errors++;
          $display("FAIL hold_stable got v=%b w=%h expected v=1 w=%h", m_if.tvalid, {m_if.tlast, m_if.tdata}, stall_word);
        end
      end
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) obs_q.push_back({m_if.tlast, m_if.tdata});
      stall_prev = (m_if.tvalid === 1'b1 && m_if.tready === 1'b0);
      stall_word = {m_if.tlast, m_if.tdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_sample(input logic [IN_W-1:0] d, input bit stored);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    if (stored && model_accepts()) model_store(d);
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (busy === 1'b0 && m_if.tvalid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge aclk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b expected 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b expected 0", m_if.tlast); end
    checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h expected 0", m_if.tdata); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b expected 0", s_if.tready); end
    checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL rst_ovf got %0d expected 0", overflow_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d expected %0d", dbg_state, ST_IDLE); end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    next_cycle(1);
    @(negedge aclk);
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL out_of_reset_s_tready got %b expected 1", s_if.tready); end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_sign_extend();
    logic [OUT_W-1:0] lit [4];
    logic [IN_W-1:0]  smp [4];
    bit               ok;
    int               off;
    lit = '{32'h00000001, 32'hFFFFFFFF, 32'h007FFFFF, 32'hFF800000};
    smp = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
    off = HDR ? 1 : 0;
    enable = 1'b1;
    m_if.tready = 1'b1;
    send_sample(smp[0], 1'b1);
    @(negedge aclk);
    checks++; if (m_if.tvalid !== HDR) begin errors++; $display("FAIL latency_t1 got %b expected %b", m_if.tvalid, HDR); end
    @(negedge aclk);
    checks++; if (m_if.tvalid !== !HDR) begin errors++; $display("FAIL latency_t2 got %b expected %b", m_if.tvalid, !HDR); end
    @(posedge aclk);
    #1;
    for (int i = 1; i < 4; i++) send_sample(smp[i], 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sign_drain timeout busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != 4 + off) begin errors++; $display("FAIL sign_count got %0d expected %0d", obs_q.size(), 4 + off); end
`ifdef AXIS_FRAMER_HEADER_EN
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== {1'b0, 32'hAD760000}) begin errors++; $display("FAIL sign_header got %h expected %h", obs_q[0], {1'b0, 32'hAD760000}); end
    end
`endif
    for (int i = 0; i < 4 && i + off < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i+off] !== {(i == 3), lit[i]}) begin
        errors++;
        $display("FAIL sign_word[%0d] got %h expected %h", i, obs_q[i+off], {(i == 3), lit[i]});
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    enable = 1'b1;
    m_if.tready = 1'b0;
    for (int i = 0; i < 20; i++) send_sample(IN_W'($urandom), i < CAP);
    exp_ovf = 20 - CAP;
    @(negedge aclk);
    checks++; if (overflow_cnt !== 16'(exp_ovf)) begin errors++; $display("FAIL ovf_count got %0d expected %0d", overflow_cnt, exp_ovf); end
    @(posedge aclk);
    #1;
    overflow_clr = 1'b1;
    next_cycle(1);
    overflow_clr = 1'b0;
    @(negedge aclk);
    checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL ovf_clear got %0d expected 0", overflow_cnt); end
    @(posedge aclk);
    #1;
    overflow_clr = 1'b1;
    send_sample(IN_W'($urandom), 1'b0);
    overflow_clr = 1'b0;
    @(negedge aclk);
    checks++; if (overflow_cnt !== 16'd1) begin errors++; $display("FAIL ovf_clr_and_drop got %0d expected 1", overflow_cnt); end
    @(posedge aclk);
    #1;
    send_sample(IN_W'($urandom), 1'b0);
    exp_ovf = 2;
    @(negedge aclk);
    checks++; if (overflow_cnt !== 16'd2) begin errors++; $display("FAIL ovf_after_clr got %0d expected 2", overflow_cnt); end
    @(posedge aclk);
    #1;
    m_if.tready = 1'b1;
    next_cycle(3);
    while (open_cnt != 0) send_sample(IN_W'($urandom), 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain timeout busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_beats got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (overflow_cnt !== 16'(exp_ovf)) begin errors++; $display("FAIL ovf_hold got %0d expected %0d", overflow_cnt, exp_ovf); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_enable_drop();
    bit ok;
    m_if.tready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) send_sample(IN_W'($urandom), 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) send_sample(IN_W'($urandom), 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_drain timeout busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL en_beats got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_word[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (overflow_cnt !== 16'(exp_ovf)) begin errors++; $display("FAIL en_ovf got %0d expected %0d", overflow_cnt, exp_ovf); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL en_state got %0d expected %0d", dbg_state, ST_IDLE); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    m_if.tready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3 * FLEN; i++) send_sample(IN_W'($urandom), 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain timeout busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_beats got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 600; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      m_if.tready = ($urandom_range(0, 9) < 7);
      s_if.tvalid = ($urandom_range(0, 3) == 0);
      s_if.tdata  = IN_W'($urandom);
      if (s_if.tvalid && model_accepts()) model_store(s_if.tdata);
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b0;
    enable = 1'b1;
    m_if.tready = 1'b1;
    while (open_cnt != 0) send_sample(IN_W'($urandom), 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_drain timeout busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_beats got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (overflow_cnt !== 16'(exp_ovf)) begin errors++; $display("FAIL rnd_ovf got %0d expected %0d", overflow_cnt, exp_ovf); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    enable = 1'b1;
    m_if.tready = 1'b0;
    for (int i = 0; i < 2; i++) send_sample(IN_W'($urandom), 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got %b expected 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL mid_rst_tlast got %b expected 0", m_if.tlast); end
    checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL mid_rst_tdata got %h expected 0", m_if.tdata); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_tready got %b expected 0", s_if.tready); end
    checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_ovf got %0d expected 0", overflow_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b expected 0", busy); end
    open_cnt = 0;
    seq_m = '0;
    exp_ovf = 0;
    exp_q.delete();
    obs_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_if.tready = 1'b1;
    next_cycle(1);
    for (int i = 0; i < 3 * FLEN; i++) send_sample(IN_W'($urandom), 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_drain timeout busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL post_rst_beats got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_rst_word[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef AXIS_FRAMER_HEADER_EN
    if (obs_q.size() >= 3 * (FLEN + 1)) begin
      checks++; if (obs_q[0] !== {1'b0, 32'hAD760000}) begin errors++; $display("FAIL hdr0 got %h expected %h", obs_q[0], {1'b0, 32'hAD760000}); end
      checks++; if (obs_q[FLEN+1] !== {1'b0, 32'hAD760001}) begin errors++; $display("FAIL hdr1 got %h expected %h", obs_q[FLEN+1], {1'b0, 32'hAD760001}); end
      checks++; if (obs_q[2*(FLEN+1)] !== {1'b0, 32'hAD760002}) begin errors++; $display("FAIL hdr2 got %h expected %h", obs_q[2*(FLEN+1)], {1'b0, 32'hAD760002}); end
    end
`endif
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    test_reset();
    test_sign_extend();
    test_overflow();
    test_enable_drop();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
